booth_mac_collector: RTL and testbench

//   Downstream consumer of booth_mult. Detects each completed product (rising edge of done),

---
 rtl/booth_mac_collector_pkg.sv | 20 ++
 rtl/booth_mac_collector_sync_fifo.sv | 73 +++++++
 rtl/booth_mac_collector.sv | 139 +++++++++++++
 tb/tb_booth_mac_collector.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mac_collector_pkg.sv
// Shared types and sizing helpers for the Booth MAC collector.
// No logic of its own.
// Used by both the top level and its output FIFO.
package booth_mac_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PUSH = 2'd2
    } state_t;

    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/booth_mac_collector_sync_fifo.sv
// Generic synchronous FIFO with occupancy level and registered storage.
// Latency: a write is visible at the head on the cycle after it is accepted.
// Backpressure: wr_rdy drops when full, unless a pop frees a slot in the same cycle.
module sync_fifo
    import booth_mac_collector_pkg::*;
#(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int LVL_W = lvl_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] cnt;
    logic             full;
    logic             empty;
    logic             wr_fire;
    logic             rd_fire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt == LVL_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign rd_fire = rd_rdy && !empty;
    assign wr_rdy  = !full || rd_fire;
    assign wr_fire = wr_vld && wr_rdy;

    assign rd_vld = !empty;
    assign rd_dat = mem[rd_ptr];
    assign level  = cnt;

    // Storage is cleared too so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_fire) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (rd_fire) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_fire, rd_fire})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/booth_mac_collector.sv
// Sums BLOCK_LEN Booth products into a saturating accumulator and queues block results.
// Latency: FIFO write one cycle after the final product edge, head valid one cycle later.
// Backpressure: out_valid/out_ready drain; a block arriving at a full FIFO is dropped, drop_err set.
module booth_mac_collector
    import booth_mac_collector_pkg::*;
#(
    parameter int D_IN       = 8,
    parameter int ACC_W      = 20,
    parameter int BLOCK_LEN  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          mult_done,
    input  logic [2*D_IN-1:0]             mult_m,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_data,
    output logic                          out_sat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          drop_err
);

    localparam int CNT_W = $clog2(BLOCK_LEN + 1);
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t             state_q;
    state_t             state_d;
    logic               done_q;
    logic               evt;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               blk_sat;
    logic [ACC_W-1:0]   m_ext;
    logic [ACC_W:0]     sum_x;
    logic               ovf;
    logic [ACC_W-1:0]   sum_sat;
    logic               last;
    logic               start;
    logic               accum;
    logic               push_vld;
    logic               fifo_wr_rdy;
    logic [ACC_W:0]     head_dat;

    assign evt   = mult_done & ~done_q;
    assign m_ext = ACC_W'($signed(mult_m));

    // One guard bit catches overflow; the clamp direction follows its sign.
    assign sum_x   = {acc[ACC_W-1], acc} + {m_ext[ACC_W-1], m_ext};
    assign ovf     = sum_x[ACC_W] ^ sum_x[ACC_W-1];
    assign sum_sat = ovf ? (sum_x[ACC_W] ? SAT_MIN : SAT_MAX) : sum_x[ACC_W-1:0];
    assign last    = (cnt == CNT_W'(BLOCK_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state_q <= ST_IDLE;
        else if (clr) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (evt) state_d = (BLOCK_LEN == 1) ? ST_PUSH : ST_RUN;
            ST_RUN:  if (evt && last) state_d = ST_PUSH;
            ST_PUSH: state_d = evt ? ((BLOCK_LEN == 1) ? ST_PUSH : ST_RUN) : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        push_vld = 1'b0;
        start    = 1'b0;
        accum    = 1'b0;
        case (state_q)
            ST_IDLE: start = evt;
            ST_RUN:  accum = evt;
            ST_PUSH: begin
                push_vld = 1'b1;
                start    = evt;
            end
            default: ;
        endcase
    end

    // In PUSH the registered acc is the finished block; a same-cycle event reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            blk_sat  <= 1'b0;
            drop_err <= 1'b0;
        end else if (clr) begin
            done_q   <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            blk_sat  <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            done_q <= mult_done;
            if (start) begin
                acc     <= m_ext;
                cnt     <= CNT_W'(1);
                blk_sat <= 1'b0;
            end else if (accum) begin
                acc     <= sum_sat;
                cnt     <= cnt + 1'b1;
                blk_sat <= blk_sat | ovf;
            end else if (push_vld) begin
                acc     <= '0;
                cnt     <= '0;
                blk_sat <= 1'b0;
            end
            if (push_vld && !fifo_wr_rdy) drop_err <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (ACC_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .wr_vld (push_vld),
        .wr_dat ({blk_sat, acc}),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (head_dat),
        .level  (fifo_level)
    );

    assign out_sat  = head_dat[ACC_W];
    assign out_data = head_dat[ACC_W-1:0];

endmodule

// File: tb/tb_booth_mac_collector.sv
// Bench for booth_mac_collector: directed block scenarios plus random products against a queue model.
module tb_booth_mac_collector;

    localparam int D_IN       = 8;
    localparam int ACC_W      = 20;
    localparam int BLOCK_LEN  = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int SMAX       = 2**(ACC_W-1) - 1;
    localparam int SMIN       = -(2**(ACC_W-1));

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             mult_done = 1'b0;
    logic [15:0]      mult_m = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_data;
    logic             out_sat;
    logic [LVL_W-1:0] fifo_level;
    logic             drop_err;

    // narrow-accumulator instance for the saturation case
    logic             done_s = 1'b0;
    logic [15:0]      m_s = '0;
    logic             valid_s;
    logic             ready_s = 1'b0;
    logic [15:0]      data_s;
    logic             sat_s;
    logic [LVL_W-1:0] level_s;
    logic             drop_s;

    always #5 clk = ~clk;

    booth_mac_collector #(.D_IN(D_IN), .ACC_W(ACC_W), .BLOCK_LEN(BLOCK_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mult_done(mult_done), .mult_m(mult_m),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .fifo_level(fifo_level), .drop_err(drop_err)
    );

    booth_mac_collector #(.D_IN(D_IN), .ACC_W(16), .BLOCK_LEN(BLOCK_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mult_done(done_s), .mult_m(m_s),
        .out_valid(valid_s), .out_ready(ready_s), .out_data(data_s), .out_sat(sat_s),
        .fifo_level(level_s), .drop_err(drop_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: block sums in plain integers, output FIFO as a queue.
    int mq_dat[$];
    bit mq_sat[$];
    bit m_drop = 1'b0;
    int m_acc = 0;
    int m_cnt = 0;
    bit m_bsat = 1'b0;
    bit m_prev = 1'b0;
    bit m_pend = 1'b0;
    int m_pdat = 0;
    bit m_psat = 1'b0;

    task model_reset();
        mq_dat.delete();
        mq_sat.delete();
        m_drop = 1'b0;
        m_acc  = 0;
        m_cnt  = 0;
        m_bsat = 1'b0;
        m_prev = 1'b0;
        m_pend = 1'b0;
    endtask

    task model_step();
        bit pop;
        bit evt;
        int m;
        int s;
        pop = out_ready && (mq_dat.size() > 0);
        evt = mult_done && !m_prev;
        m   = int'($signed(mult_m));
        if (pop) begin
            void'(mq_dat.pop_front());
            void'(mq_sat.pop_front());
        end
        if (m_pend) begin
            if (mq_dat.size() < FIFO_DEPTH) begin
                mq_dat.push_back(m_pdat);
                mq_sat.push_back(m_psat);
            end else begin
                m_drop = 1'b1;
            end
        end
        m_pend = 1'b0;
        if (evt) begin
            if (m_cnt == 0) begin
                m_acc  = m;
                m_bsat = 1'b0;
            end else begin
                s = m_acc + m;
                if (s > SMAX) begin s = SMAX; m_bsat = 1'b1; end
                if (s < SMIN) begin s = SMIN; m_bsat = 1'b1; end
                m_acc = s;
            end
            m_cnt++;
            if (m_cnt == BLOCK_LEN) begin
                m_pend = 1'b1;
                m_pdat = m_acc;
                m_psat = m_bsat;
                m_cnt  = 0;
            end
        end
        m_prev = mult_done;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)   model_reset();
        else if (clr) model_reset();
        else          model_step();
    end

    logic [ACC_W:0] got_q[$];

    always @(negedge clk) begin
        chk("valid", out_valid, mq_dat.size() > 0);
        chk("level", fifo_level, mq_dat.size());
        chk("drop_err", drop_err, m_drop);
        if (mq_dat.size() > 0) begin
            chk("data", $signed(out_data), mq_dat[0]);
            chk("sat", out_sat, mq_sat[0]);
        end
        if (out_valid && out_ready) got_q.push_back({out_sat, out_data});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [15:0] m, input int hold, input int gap);
        mult_m    = m;
        mult_done = 1'b1;
        tick(hold);
        mult_done = 1'b0;
        mult_m    = 16'($urandom);
        tick(gap);
    endtask

    task automatic prod(input int a, input int b);
        pulse(16'(a * b), 1, 1);
    endtask

    task automatic pulse_s(input logic [15:0] m);
        m_s    = m;
        done_s = 1'b1;
        tick(1);
        done_s = 1'b0;
        tick(1);
    endtask

    task automatic chk_word(input string tag, input int idx, input int exp_dat, input bit exp_sat);
        logic [ACC_W:0] w;
        if (idx < got_q.size()) begin
            w = got_q[idx];
            chk(tag, $signed(w[ACC_W-1:0]), exp_dat);
            chk({tag, "_sat"}, w[ACC_W], exp_sat);
        end else begin
            chk({tag, "_present"}, got_q.size(), idx + 1);
        end
    endtask

    initial begin
        tick(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_data", out_data, 0);
        chk("rst_drop", drop_err, 0);
        rst_n = 1'b1;
        tick(2);

        // mixed-sign operand block
        got_q.delete();
        out_ready = 1'b1;
        prod(127, -127);
        prod(-128, 127);
        prod(-128, -128);
        prod(-5, -11);
        tick(4);
        chk("t1_count", got_q.size(), 1);
        chk_word("t1_word", 0, -15946, 1'b0);

        // held done counts once
        got_q.delete();
        pulse(16'd55, 5, 1);
        repeat (3) pulse(16'd55, 1, 1);
        tick(4);
        chk("t2_count", got_q.size(), 1);
        chk_word("t2_word", 0, 220, 1'b0);

        // saturation on the 16-bit instance, then a clean block
        repeat (4) pulse_s(16'd16384);
        tick(2);
        chk("t3_valid", valid_s, 1);
        chk("t3_data", $signed(data_s), 32767);
        chk("t3_sat", sat_s, 1);
        ready_s = 1'b1;
        tick(1);
        ready_s = 1'b0;
        repeat (4) pulse_s(16'd1);
        tick(2);
        chk("t3_level", level_s, 1);
        chk("t3_clean_data", $signed(data_s), 4);
        chk("t3_clean_sat", sat_s, 0);

        // overflow the FIFO with backpressure, then drain
        got_q.delete();
        out_ready = 1'b0;
        repeat (5 * BLOCK_LEN) pulse(16'd1, 1, 1);
        tick(3);
        chk("t4_level", fifo_level, FIFO_DEPTH);
        chk("t4_drop", drop_err, 1);
        out_ready = 1'b1;
        tick(6);
        chk("t4_count", got_q.size(), FIFO_DEPTH);
        for (int i = 0; i < FIFO_DEPTH; i++) chk_word("t4_word", i, 4, 1'b0);
        chk("t4_empty", out_valid, 0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        chk("t4_clr_drop", drop_err, 0);

        // reset mid-block loses the partial sum
        got_q.delete();
        pulse(16'd100, 1, 1);
        pulse(16'd100, 1, 1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        repeat (4) pulse(16'd1, 1, 1);
        tick(4);
        chk("t5_count", got_q.size(), 1);
        chk_word("t5_word", 0, 4, 1'b0);

        // full FIFO with a pop exactly on the PUSH cycle
        got_q.delete();
        out_ready = 1'b0;
        for (int k = 1; k <= FIFO_DEPTH; k++) repeat (BLOCK_LEN) pulse(16'(k), 1, 1);
        tick(3);
        chk("t6_full_level", fifo_level, FIFO_DEPTH);
        repeat (BLOCK_LEN - 1) pulse(16'd5, 1, 1);
        mult_m    = 16'd5;
        mult_done = 1'b1;
        tick(1);
        mult_done = 1'b0;
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(2);
        chk("t6_level", fifo_level, FIFO_DEPTH);
        chk("t6_drop", drop_err, 0);
        out_ready = 1'b1;
        tick(8);
        chk("t6_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) chk_word("t6_word", i, 4 * (i + 1), 1'b0);

        // random products, held/merged done, random backpressure, rare clear
        for (int n = 0; n < 300; n++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) begin
                clr = 1'b1;
                tick(1);
                clr = 1'b0;
            end
            pulse(16'(a * b), int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
        end
        out_ready = 1'b1;
        tick(20);
        chk("final_empty", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
